// File: rtl/fft64_pkg.sv
// Shared constants, sample type and twiddle ROM for the 64-point streaming FFT.
// bitrev6 maps an output slot to the DFT bin it carries.
package fft64_pkg;

  localparam int N        = 64;
  localparam int LOG2N    = 6;
  localparam int WIDTH    = 16;
  localparam int TW_WIDTH = 16;

  typedef struct packed {
    logic signed [WIDTH-1:0] re;
    logic signed [WIDTH-1:0] im;
  } cplx_t;

  // First quadrant of cos(2*pi*m/64) in Q1.15; the full circle is folded onto it.
  function automatic logic signed [TW_WIDTH-1:0] tw_base(input logic [4:0] m);
    case (m)
      5'd0:    tw_base = 16'sd32767;
      5'd1:    tw_base = 16'sd32610;
      5'd2:    tw_base = 16'sd32138;
      5'd3:    tw_base = 16'sd31357;
      5'd4:    tw_base = 16'sd30274;
      5'd5:    tw_base = 16'sd28899;
      5'd6:    tw_base = 16'sd27245;
      5'd7:    tw_base = 16'sd25330;
      5'd8:    tw_base = 16'sd23170;
      5'd9:    tw_base = 16'sd20788;
      5'd10:   tw_base = 16'sd18205;
      5'd11:   tw_base = 16'sd15447;
      5'd12:   tw_base = 16'sd12540;
      5'd13:   tw_base = 16'sd9512;
      5'd14:   tw_base = 16'sd6393;
      5'd15:   tw_base = 16'sd3212;
      5'd16:   tw_base = 16'sd0;
      default: tw_base = 16'sd0;
    endcase
  endfunction

  function automatic logic signed [TW_WIDTH-1:0] tw_cos(input logic [4:0] m);
    if (m <= 5'd16) begin
      tw_cos = tw_base(m);
    end else begin
      tw_cos = -tw_base(5'd0 - m);
    end
  endfunction

  function automatic logic signed [TW_WIDTH-1:0] tw_sin(input logic [4:0] m);
    if (m <= 5'd16) begin
      tw_sin = tw_base(5'd16 - m);
    end else begin
      tw_sin = tw_base(m - 5'd16);
    end
  endfunction

  function automatic logic [5:0] bitrev6(input logic [5:0] v);
    for (int i = 0; i < 6; i++) begin
      bitrev6[i] = v[5-i];
    end
  endfunction

endpackage

// File: rtl/fft_sdf_stage.sv
// One radix-2 DIF single-path delay-feedback stage: delay line, halving butterfly,
// twiddle rotation of the difference branch and a registered output.
module fft_sdf_stage
  import fft64_pkg::*;
#(
  parameter int D      = 32,
  parameter int STRIDE = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sob_i,
  input  logic [WIDTH-1:0] re_i,
  input  logic [WIDTH-1:0] im_i,
  output logic             sob_o,
  output logic [WIDTH-1:0] re_o,
  output logic [WIDTH-1:0] im_o
);

  localparam int CW = $clog2(2 * D);

  logic [CW-1:0]             cnt_q, cnt_d, idx_s;
  logic                      sob_q, sob_d;
  logic                      bfly_s;
  cplx_t                     dl_q [D];
  cplx_t                     in_s, head_s, sum_s, rot_s, push_s, out_s, out_q;
  logic signed [WIDTH:0]     sum_re_w, sum_im_w, dif_re_w, dif_im_w;
  logic signed [WIDTH-1:0]   dr_s, di_s;
  logic signed [TW_WIDTH-1:0] cos_s, sin_s;
  logic signed [2*WIDTH-1:0] p_rc_w, p_is_w, p_ic_w, p_rs_w;
  logic signed [2*WIDTH:0]   mr_w, mi_w;
  logic [4:0]                tw_idx_s;
  logic                      unused_s;

  // Phase counter realigns on every start-of-block; the datapath is purely combinational here.
  always_comb begin
    in_s.re  = $signed(re_i);
    in_s.im  = $signed(im_i);
    idx_s    = sob_i ? '0 : cnt_q;
    cnt_d    = idx_s + CW'(1);
    bfly_s   = idx_s[CW-1];
    head_s   = dl_q[D-1];
    sum_re_w = {head_s.re[WIDTH-1], head_s.re} + {in_s.re[WIDTH-1], in_s.re};
    sum_im_w = {head_s.im[WIDTH-1], head_s.im} + {in_s.im[WIDTH-1], in_s.im};
    dif_re_w = {head_s.re[WIDTH-1], head_s.re} - {in_s.re[WIDTH-1], in_s.re};
    dif_im_w = {head_s.im[WIDTH-1], head_s.im} - {in_s.im[WIDTH-1], in_s.im};
    sum_s.re = sum_re_w[WIDTH:1];
    sum_s.im = sum_im_w[WIDTH:1];
    dr_s     = dif_re_w[WIDTH:1];
    di_s     = dif_im_w[WIDTH:1];
    tw_idx_s = 5'((int'(idx_s) % D) * STRIDE);
    cos_s    = tw_cos(tw_idx_s);
    sin_s    = tw_sin(tw_idx_s);
    // (dr + j*di) * (cos - j*sin)
    p_rc_w   = 32'(dr_s) * 32'(cos_s);
    p_is_w   = 32'(di_s) * 32'(sin_s);
    p_ic_w   = 32'(di_s) * 32'(cos_s);
    p_rs_w   = 32'(dr_s) * 32'(sin_s);
    mr_w     = 33'(p_rc_w) + 33'(p_is_w);
    mi_w     = 33'(p_ic_w) - 33'(p_rs_w);
    // W^0 is exactly one; the Q1.15 ROM can only approximate it, so bypass the multiplier.
    if (tw_idx_s == 5'd0) begin
      rot_s.re = dr_s;
      rot_s.im = di_s;
    end else begin
      rot_s.re = mr_w[WIDTH+14:15];
      rot_s.im = mi_w[WIDTH+14:15];
    end
    push_s = bfly_s ? rot_s : in_s;
    out_s  = bfly_s ? sum_s : head_s;
    sob_d  = (idx_s == CW'(D));
  end

  assign unused_s = ^{sum_re_w[0], sum_im_w[0], dif_re_w[0], dif_im_w[0],
                      mr_w[2*WIDTH:WIDTH+15], mr_w[14:0], mi_w[2*WIDTH:WIDTH+15], mi_w[14:0]};

  // Delay line shift, phase counter and output register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      sob_q <= 1'b0;
      out_q <= '0;
      for (int i = 0; i < D; i++) begin
        dl_q[i] <= '0;
      end
    end else begin
      cnt_q   <= cnt_d;
      sob_q   <= sob_d;
      out_q   <= out_s;
      dl_q[0] <= push_s;
      for (int i = 1; i < D; i++) begin
        dl_q[i] <= dl_q[i-1];
      end
    end
  end

  assign sob_o = sob_q;
  assign re_o  = out_q.re;
  assign im_o  = out_q.im;

endmodule

// File: rtl/fft64_core.sv
// Streaming 64-point radix-2 DIF SDF FFT scaled by 1/64, bit-reversed output order.
// Six cascaded stages plus input framing, abort handling and output-valid timing.
module fft64_core
  import fft64_pkg::*;
(
  input  logic             clock,
  input  logic             resetn,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im
);

  logic [LOG2N-1:0] in_cnt_q, in_cnt_d;
  logic [LOG2N-1:0] out_cnt_q, out_cnt_d;
  logic [4:0]       done_q, done_d;
  logic             do_en_q, do_en_d;
  logic             sob_s [LOG2N+1];
  logic [WIDTH-1:0] re_s  [LOG2N+1];
  logic [WIDTH-1:0] im_s  [LOG2N+1];
  logic             unused_s;

  assign sob_s[0] = di_en && (in_cnt_q == 6'd0);
  assign re_s[0]  = di_en ? di_re : '0;
  assign im_s[0]  = di_en ? di_im : '0;

  for (genvar s = 0; s < LOG2N; s++) begin : g_stage
    fft_sdf_stage #(
      .D      ((N / 2) >> s),
      .STRIDE (1 << s)
    ) u_stage (
      .clk_i  (clock),
      .rst_ni (resetn),
      .sob_i  (sob_s[s]),
      .re_i   (re_s[s]),
      .im_i   (im_s[s]),
      .sob_o  (sob_s[s+1]),
      .re_o   (re_s[s+1]),
      .im_o   (im_s[s+1])
    );
  end

  // A completed block opens a 64-cycle output window once the last sample clears the stage registers.
  always_comb begin
    in_cnt_d  = di_en ? (in_cnt_q + 6'd1) : 6'd0;
    done_d    = {done_q[3:0], di_en && (in_cnt_q == 6'(N - 1))};
    do_en_d   = 1'b0;
    out_cnt_d = out_cnt_q;
    if (done_q[4]) begin
      do_en_d   = 1'b1;
      out_cnt_d = 6'(N - 1);
    end else if (out_cnt_q != 6'd0) begin
      do_en_d   = 1'b1;
      out_cnt_d = out_cnt_q - 6'd1;
    end else begin
      do_en_d   = 1'b0;
      out_cnt_d = 6'd0;
    end
  end

  // Framing and output-valid state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      in_cnt_q  <= 6'd0;
      out_cnt_q <= 6'd0;
      done_q    <= 5'd0;
      do_en_q   <= 1'b0;
    end else begin
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      done_q    <= done_d;
      do_en_q   <= do_en_d;
    end
  end

  assign unused_s = sob_s[LOG2N];
  assign do_en    = do_en_q;
  assign do_re    = re_s[LOG2N];
  assign do_im    = im_s[LOG2N];

endmodule

// File: tb/tb_fft64_core.sv
// Directed bench for fft64_core: impulse, DC, cosine, back-to-back, abort and mid-flight reset.
module tb_fft64_core;
  import fft64_pkg::*;

  logic             clock = 1'b0;
  logic             resetn;
  logic             di_en;
  logic [WIDTH-1:0] di_re, di_im;
  logic             do_en;
  logic [WIDTH-1:0] do_re, do_im;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t_drive;
  int blk_re [64];
  int blk_im [64];
  int cap_re [$];
  int cap_im [$];
  int cap_cyc [$];

  fft64_core dut (
    .clock  (clock),
    .resetn (resetn),
    .di_en  (di_en),
    .di_re  (di_re),
    .di_im  (di_im),
    .do_en  (do_en),
    .do_re  (do_re),
    .do_im  (do_im)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (do_en) begin
      cap_re.push_back(int'($signed(do_re)));
      cap_im.push_back(int'($signed(do_im)));
      cap_cyc.push_back(cyc);
    end
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int near(input int v, input int e, input int tol);
    return ((v - e) <= tol && (e - v) <= tol) ? e : v;
  endfunction

  task automatic drive(input logic en, input int re, input int im);
    @(negedge clock);
    di_en = en;
    di_re = WIDTH'(re);
    di_im = WIDTH'(im);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 0);
  endtask

  task automatic send_block();
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, blk_re[i], blk_im[i]);
      if (i == 0) t_drive = cyc;
    end
  endtask

  task automatic clear_capture();
    cap_re.delete();
    cap_im.delete();
    cap_cyc.delete();
  endtask

  task automatic fill(input int kind);
    real r;
    for (int n = 0; n < 64; n++) begin
      blk_im[n] = 0;
      if (kind == 0) begin
        blk_re[n] = (n == 0) ? 1000 : 0;
      end else if (kind == 1) begin
        blk_re[n] = 1000;
      end else begin
        r = 1024.0 * $cos(2.0 * 3.14159265358979 * n / 64.0);
        blk_re[n] = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
      end
    end
  endtask

  // kind 0 impulse (every slot 15), 1 DC (bin 0 = 1000), 2 cosine (bins 1 and 63 = 512)
  task automatic check_block(input string tag, input int base, input int kind, input int tol);
    int bin, exp_re;
    for (int k = 0; k < 64; k++) begin
      if (base + k < cap_re.size()) begin
        bin = int'(bitrev6(6'(k)));
        if (kind == 0) exp_re = 15;
        else if (kind == 1) exp_re = (bin == 0) ? 1000 : 0;
        else exp_re = (bin == 1 || bin == 63) ? 512 : 0;
        check_val($sformatf("%s_re[%0d]", tag, k), near(cap_re[base+k], exp_re, tol), exp_re);
        check_val($sformatf("%s_im[%0d]", tag, k), near(cap_im[base+k], 0, tol), 0);
      end
    end
  endtask

  task automatic check_frame(input string tag, input int n_exp, input int t0);
    check_val({tag, "_count"}, cap_re.size(), n_exp);
    if (cap_cyc.size() > 0) begin
      check_val({tag, "_latency"}, cap_cyc[0] - t0, 69);
      check_val({tag, "_contig"}, cap_cyc[cap_cyc.size()-1] - cap_cyc[0], cap_cyc.size() - 1);
    end
  endtask

  initial begin
    int t0;
    resetn = 1'b0;
    di_en  = 1'b0;
    di_re  = '0;
    di_im  = '0;
    repeat (3) @(negedge clock);
    check_val("rst_do_en", int'(do_en), 0);
    check_val("rst_do_re", int'(do_re), 0);
    check_val("rst_do_im", int'(do_im), 0);
    resetn = 1'b1;
    idle(2);

    clear_capture();
    fill(0);
    send_block();
    t0 = t_drive;
    idle(100);
    check_frame("imp", 64, t0);
    check_block("imp", 0, 0, 0);

    clear_capture();
    fill(1);
    send_block();
    t0 = t_drive;
    idle(100);
    check_frame("dc", 64, t0);
    check_block("dc", 0, 1, 1);

    clear_capture();
    fill(2);
    send_block();
    t0 = t_drive;
    idle(100);
    check_frame("cos", 64, t0);
    check_block("cos", 0, 2, 2);

    clear_capture();
    fill(0);
    send_block();
    t0 = t_drive;
    fill(1);
    send_block();
    idle(100);
    check_frame("b2b", 128, t0);
    check_block("b2b_imp", 0, 0, 0);
    check_block("b2b_dc", 64, 1, 1);

    clear_capture();
    for (int i = 0; i < 20; i++) drive(1'b1, 777, -333);
    drive(1'b0, 0, 0);
    fill(1);
    send_block();
    t0 = t_drive;
    idle(100);
    check_frame("abort", 64, t0);
    check_block("abort_dc", 0, 1, 1);

    fill(0);
    send_block();
    t0 = t_drive;
    repeat (17) drive(1'b0, 0, 0);
    check_val("rst_mid_pre_en", int'(do_en), 1);
    resetn = 1'b0;
    #1;
    check_val("rst_mid_do_en", int'(do_en), 0);
    check_val("rst_mid_do_re", int'(do_re), 0);
    idle(3);
    resetn = 1'b1;
    idle(2);
    clear_capture();
    send_block();
    t0 = t_drive;
    idle(100);
    check_frame("post_rst", 64, t0);
    check_block("post_rst", 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
